// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC and issues one instruction memory read per cycle.
// Returned words go into a small FIFO that feeds decode over valid/ready.
module fetch_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned BUF_DEPTH  = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             imem_rd_en,
  output logic [31:0]      imem_pc,
  input  logic [WIDTH-1:0] imem_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [31:0]      out_pc,
  output logic             fault,
  output logic [31:0]      fault_pc
);

  localparam int unsigned PW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned OW       = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ipc_q;
  logic [31:0]      fault_pc_q, fault_pc_d;
  logic             inflight_q, inflight_d;
  logic             kill_q, kill_d;
  logic             fault_q, fault_d;

  logic [WIDTH-1:0] buf_instr [BUF_DEPTH];
  logic [31:0]      buf_pc    [BUF_DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [OW-1:0]    occ_q;

  logic             redir;
  logic             pop_req;
  logic             do_pop;
  logic             push;
  logic             issue;
  logic [31:0]      used;

  function automatic logic pc_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < PC_LIMIT);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign redir     = redirect_valid && (state_q != S_IDLE);
  assign out_valid = (occ_q != '0);
  assign pop_req   = out_valid & out_ready;
  assign do_pop    = pop_req & ~redir;
  // a redirect flushes the buffer, so the word arriving in that cycle is dropped too
  assign push      = inflight_q & ~kill_q & ~redir;
  assign used      = 32'(occ_q) + 32'(inflight_q) - 32'(pop_req);

  assign imem_rd_en = issue;
  assign imem_pc    = pc_q;
  assign out_instr  = out_valid ? buf_instr[rd_ptr_q] : '0;
  assign out_pc     = out_valid ? buf_pc[rd_ptr_q]    : '0;
  assign fault      = fault_q;
  assign fault_pc   = fault_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = 1'b0;
    kill_d     = 1'b0;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    issue      = 1'b0;
    if (redir) begin
      pc_d   = redirect_pc;
      kill_d = inflight_q;
      if (pc_legal(redirect_pc)) begin
        fault_d = 1'b0;
        state_d = S_FETCH;
      end else begin
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
        state_d    = S_FAULT;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            pc_d    = RESET_PC;
          end
        end
        S_FETCH: begin
          if (!pc_legal(pc_q)) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            state_d    = S_FAULT;
          end else if (used < 32'(BUF_DEPTH)) begin
            issue      = 1'b1;
            pc_d       = pc_q + 32'd4;
            inflight_d = 1'b1;
          end
        end
        S_FAULT: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      if (issue) ipc_q <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else if (redir) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push)   wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_q + OW'(push) - OW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr_q] <= imem_instr;
      buf_pc[wr_ptr_q]    <= ipc_q;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed sequence with a scoreboard of expected {pc, instr} deliveries.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_rd_en;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  fetch_ctrl #(
    .WIDTH(32),
    .IMEM_DEPTH(32),
    .BUF_DEPTH(2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_rd_en(imem_rd_en),
    .imem_pc(imem_pc),
    .imem_instr(imem_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .fault(fault),
    .fault_pc(fault_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous instruction memory: word k holds 0x1000_0000 + k
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) imem_instr <= '0;
    else if (imem_rd_en) imem_instr <= 32'h1000_0000 + (imem_pc >> 2);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input logic [31:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = base + 32'(4 * i);
      e.instr = 32'h1000_0000 + (e.pc >> 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic mon();
    exp_t e;
    vectors++;
    assert ((dut.occ_q <= 2) === 1'b1) else begin
      miscompares++;
      $error("FAIL occ_bound: observed %0d expected <= 2", dut.occ_q);
    end
    if (rst_n && !redirect_valid && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_delivery: observed pc %h expected none", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_instr", out_instr, e.instr);
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    mon();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    half();
    next();
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b1;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rd_en", 32'(imem_rd_en), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_fault_pc", fault_pc, 0);
    next();
    next();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      half(); chk("idle_no_issue", 32'(imem_rd_en), 0); next();
    end

    // streaming from start
    start = 1'b1;
    half(); chk("start_cycle_rd_en", 32'(imem_rd_en), 0); next();
    start = 1'b0;
    push_run(32'h0, 16);
    half(); chk("first_rd_en", 32'(imem_rd_en), 1); chk("first_imem_pc", imem_pc, 0);
    chk("lat_valid1", 32'(out_valid), 0); next();
    half(); chk("lat_valid2", 32'(out_valid), 0); chk("second_imem_pc", imem_pc, 4); next();
    for (int i = 0; i < 8; i++) begin
      half(); chk("stream_valid", 32'(out_valid), 1); next();
    end

    // backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      half();
      chk("bp_rd_en", 32'(imem_rd_en), 0);
      chk("bp_out_pc", out_pc, 32'h20);
      chk("bp_out_instr", out_instr, 32'h1000_0008);
      next();
    end
    out_ready = 1'b1;
    half(); chk("bp_rel_valid", 32'(out_valid), 1); chk("bp_rel_rd_en", 32'(imem_rd_en), 1);
    chk("bp_rel_imem_pc", imem_pc, 32'h28); next();
    for (int i = 0; i < 3; i++) begin
      half(); chk("bp_rel_stream", 32'(out_valid), 1); next();
    end

    // redirect with buffered and in-flight words under backpressure
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h10;
    exp_q.delete(); push_run(32'h10, 8);
    half(); chk("redir_rd_en", 32'(imem_rd_en), 0); next();
    redirect_valid = 1'b0; out_ready = 1'b1;
    half(); chk("redir_flush", 32'(out_valid), 0); chk("redir_issue", 32'(imem_rd_en), 1);
    chk("redir_imem_pc", imem_pc, 32'h10); next();
    half(); chk("redir_no_stale", 32'(out_valid), 0); next();
    half(); chk("redir_first_valid", 32'(out_valid), 1); chk("redir_first_pc", out_pc, 32'h10);
    chk("redir_first_instr", out_instr, 32'h1000_0004); next();
    for (int i = 0; i < 3; i++) cyc();

    // redirect + pop + arriving response together
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    exp_q.delete(); push_run(32'h40, 8);
    half(); chk("simul_pop_present", 32'(out_valid), 1); chk("simul_rd_en", 32'(imem_rd_en), 0); next();
    redirect_valid = 1'b0;
    half(); chk("simul_empty", 32'(out_valid), 0); next();
    half(); chk("simul_empty2", 32'(out_valid), 0); next();
    half(); chk("simul_first_pc", out_pc, 32'h40); next();
    for (int i = 0; i < 2; i++) cyc();

    // range fault after last legal word
    redirect_valid = 1'b1; redirect_pc = 32'h7C;
    exp_q.delete(); push_run(32'h7C, 1);
    cyc();
    redirect_valid = 1'b0;
    half(); chk("last_rd_en", 32'(imem_rd_en), 1); chk("last_imem_pc", imem_pc, 32'h7C); next();
    half(); chk("range_no_issue", 32'(imem_rd_en), 0); chk("range_fault_pre", 32'(fault), 0); next();
    half(); chk("range_fault", 32'(fault), 1); chk("range_fault_pc", fault_pc, 32'h80);
    chk("range_drain_valid", 32'(out_valid), 1); chk("range_drain_pc", out_pc, 32'h7C);
    chk("range_rd_en", 32'(imem_rd_en), 0); next();
    start = 1'b1;
    half(); chk("fault_empty", 32'(out_valid), 0); chk("fault_start_ignored", 32'(imem_rd_en), 0); next();
    start = 1'b0;
    half(); chk("fault_held", 32'(fault), 1); chk("fault_rd_en", 32'(imem_rd_en), 0); next();

    // misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h06;
    exp_q.delete();
    cyc();
    redirect_valid = 1'b0;
    half(); chk("align_fault", 32'(fault), 1); chk("align_fault_pc", fault_pc, 32'h06);
    chk("align_rd_en", 32'(imem_rd_en), 0); next();
    half(); chk("align_rd_en2", 32'(imem_rd_en), 0); next();

    // recovery
    redirect_valid = 1'b1; redirect_pc = 32'h00;
    push_run(32'h0, 8);
    cyc();
    redirect_valid = 1'b0;
    half(); chk("recover_fault", 32'(fault), 0); chk("recover_rd_en", 32'(imem_rd_en), 1);
    chk("recover_imem_pc", imem_pc, 0); next();
    cyc();
    half(); chk("recover_valid", 32'(out_valid), 1); chk("recover_pc", out_pc, 0); next();
    for (int i = 0; i < 3; i++) cyc();

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_rd_en", 32'(imem_rd_en), 0);
    chk("arst_out_pc", out_pc, 0);
    chk("arst_out_instr", out_instr, 0);
    chk("arst_fault", 32'(fault), 0);
    exp_q.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      half(); chk("arst_no_issue", 32'(imem_rd_en), 0); chk("arst_no_valid", 32'(out_valid), 0); next();
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    push_run(32'h0, 4);
    half(); chk("arst_first_rd_en", 32'(imem_rd_en), 1); chk("arst_first_imem_pc", imem_pc, 0); next();
    cyc();
    half(); chk("arst_first_valid", 32'(out_valid), 1); chk("arst_first_pc", out_pc, 0); next();
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
